// File: rtl/udp_tx_sched_pkg.sv
// Shared types for the UDP TX payload FIFO read scheduler.
// State encoding and the frame length width.
package udp_tx_sched_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    SEND      = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/udp_tx_flush_timer.sv
// Idle flush timer: counts enabled cycles, flags FLUSH_TIMEOUT-1.
// Clear wins over enable.
module udp_tx_flush_timer #(
  parameter int FLUSH_TIMEOUT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW =
    (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == CW'(FLUSH_TIMEOUT - 1));

endmodule

// File: rtl/udp_tx_fifo_sched.sv
// UDP TX payload FIFO read scheduler: frames the FIFO contents
// by size or idle timeout and drains them into the TX engine.
module udp_tx_fifo_sched
  import udp_tx_sched_pkg::*;
#(
  parameter int DEPTH_WIDTH   = 12,
  parameter int PKT_LEN       = 1024,
  parameter int FLUSH_TIMEOUT = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DEPTH_WIDTH:0] fifo_rd_water_level,
  input  logic                 fifo_rd_empty,
  output logic                 fifo_rd_en,
  input  logic [7:0]           fifo_rd_data,
  output logic                 udp_tx_start,
  input  logic                 udp_tx_ready,
  output logic [LEN_W-1:0]     udp_tx_len,
  input  logic                 udp_tx_data_req,
  output logic [7:0]           udp_tx_data,
  output logic                 udp_tx_data_valid,
  input  logic                 udp_tx_done,
  output logic                 underrun_err,
  output logic [15:0]          frame_cnt
);

  localparam int LW = DEPTH_WIDTH + 1;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LW-1:0]    rem_q, rem_d;
  logic [15:0]      fcnt_q, fcnt_d;
  logic             valid_q;

  logic lvl_nz, full_pkt, rem_nz;
  logic tmr_tc, tmr_clr, tmr_en;
  logic start, rd_en, underrun;

  assign lvl_nz   = |fifo_rd_water_level;
  assign full_pkt = fifo_rd_water_level >= LW'(PKT_LEN);
  assign rem_nz   = |rem_q;

  // Timer runs only while waiting with data; any exit from IDLE resets it.
  assign tmr_en  = (state_q == IDLE) & lvl_nz;
  assign tmr_clr = (state_q != IDLE) | ~lvl_nz
                 | (state_d != IDLE);

  udp_tx_flush_timer #(
    .FLUSH_TIMEOUT(FLUSH_TIMEOUT)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr_i(tmr_clr),
    .en_i (tmr_en),
    .tc_o (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rem_d    = rem_q;
    fcnt_d   = fcnt_q;
    start    = 1'b0;
    rd_en    = 1'b0;
    underrun = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (full_pkt) begin
          len_d   = LEN_W'(PKT_LEN);
          state_d = REQ;
        end else if (lvl_nz && tmr_tc) begin
          len_d   = LEN_W'(fifo_rd_water_level);
          state_d = REQ;
        end
      end
      REQ: begin
        start = 1'b1;
        if (udp_tx_ready) begin
          rem_d   = len_q[LW-1:0];
          state_d = SEND;
        end
      end
      SEND: begin
        if (udp_tx_data_req && rem_nz) begin
          if (fifo_rd_empty) begin
            underrun = 1'b1;
          end else begin
            rd_en = 1'b1;
            rem_d = rem_q - 1'b1;
            if (rem_q == LW'(1))
              state_d = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        if (udp_tx_done) begin
          fcnt_d  = fcnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      rem_q   <= '0;
      fcnt_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      fcnt_q  <= fcnt_d;
      valid_q <= rd_en;
    end
  end

  assign fifo_rd_en        = rd_en;
  assign udp_tx_start      = start;
  assign udp_tx_len        = len_q;
  assign udp_tx_data       = fifo_rd_data;
  assign udp_tx_data_valid = valid_q;
  assign underrun_err      = underrun;
  assign frame_cnt         = fcnt_q;

endmodule

// File: tb/tb_udp_tx_fifo_sched.sv
// Directed bench for udp_tx_fifo_sched with a behavioural
// payload FIFO whose byte k holds 8'hFF - k.
module tb_udp_tx_fifo_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] level;
  logic        empty;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        start;
  logic        ready = 1'b1;
  logic [15:0] len;
  logic        data_req = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        done = 1'b0;
  logic        underrun;
  logic [15:0] fcnt;

  logic       force_empty = 1'b0;
  int         wr_n = 0;
  int         wp = 0;
  int         rp = 0;
  logic [7:0] mem [4096];

  int n_cmp = 0;
  int n_err = 0;
  int vcnt  = 0;

  udp_tx_fifo_sched #(
    .DEPTH_WIDTH  (12),
    .PKT_LEN      (1024),
    .FLUSH_TIMEOUT(50)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .fifo_rd_water_level(level),
    .fifo_rd_empty      (empty),
    .fifo_rd_en         (rd_en),
    .fifo_rd_data       (rd_data),
    .udp_tx_start       (start),
    .udp_tx_ready       (ready),
    .udp_tx_len         (len),
    .udp_tx_data_req    (data_req),
    .udp_tx_data        (tx_data),
    .udp_tx_data_valid  (tx_valid),
    .udp_tx_done        (done),
    .underrun_err       (underrun),
    .frame_cnt          (fcnt)
  );

  always #5 clk = ~clk;

  assign level = 13'(wp - rp);
  assign empty = force_empty | (wp == rp);

  always @(posedge clk) begin
    for (int k = 0; k < wr_n; k++)
      mem[12'(wp + k)] <= 8'hFF - 8'(wp + k);
    if (rd_en) begin
      rd_data <= mem[12'(rp)];
      rp      <= rp + 1;
    end
    wp <= wp + wr_n;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  // One sample point per clock; every delivered byte is checked here.
  task automatic cyc();
    logic [7:0] eb;
    @(negedge clk);
    #1;
    if (tx_valid) begin
      eb = 8'hFF - 8'(vcnt);
      n_cmp++;
      assert (tx_data === eb) else begin
        n_err++;
        $error("FAIL data[%0d] observed=%h expected=%h",
               vcnt, tx_data, eb);
      end
      vcnt++;
    end
  endtask

  task automatic write(input int n);
    wr_n = n;
    @(posedge clk);
    #1;
    wr_n = 0;
  endtask

  task automatic wait_start(input int exp_n,
                            input int exp_len);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!start && n < 300);
    chk("start_lat", n, exp_n);
    chk("start", {31'd0, start}, 1);
    chk("len", {16'd0, len}, exp_len);
  endtask

  task automatic drain(input int exp_len);
    int v0;
    int n;
    v0 = vcnt;
    n = 0;
    while (!rd_en && n < 20) begin
      cyc();
      n++;
    end
    n = 0;
    while (rd_en && n < 5000) begin
      cyc();
      n++;
    end
    chk("bytes", vcnt - v0, exp_len);
    chk("rd_en_off", {31'd0, rd_en}, 0);
  endtask

  task automatic done_frame(input int dly,
                            input int exp_cnt);
    repeat (dly) cyc();
    done = 1'b1;
    cyc();
    done = 1'b0;
    chk("frame_cnt", {16'd0, fcnt}, exp_cnt);
  endtask

  initial begin
    int v0;
    int n;

    // reset values
    cyc();
    cyc();
    chk("rst_rd_en", {31'd0, rd_en}, 0);
    chk("rst_start", {31'd0, start}, 0);
    chk("rst_len", {16'd0, len}, 0);
    chk("rst_valid", {31'd0, tx_valid}, 0);
    chk("rst_underrun", {31'd0, underrun}, 0);
    chk("rst_fcnt", {16'd0, fcnt}, 0);
    rst = 1'b0;
    cyc();

    // full packet, engine always ready
    write(1024);
    wait_start(2, 1024);
    drain(1024);
    chk("t1_level", {19'd0, level}, 0);
    done_frame(0, 1);

    // partial packet after idle timeout
    write(100);
    wait_start(51, 100);
    drain(100);
    done_frame(3, 2);

    // two full frames then a timeout remainder
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t3_fcnt0", {16'd0, fcnt}, 0);
    write(2500);
    wait_start(2, 1024);
    drain(1024);
    done_frame(5, 1);
    wait_start(1, 1024);
    drain(1024);
    done_frame(5, 2);
    wait_start(50, 452);
    drain(452);
    done_frame(5, 3);

    // engine stalls acceptance
    ready = 1'b0;
    write(1024);
    wait_start(2, 1024);
    repeat (20) begin
      cyc();
      chk("stall_start", {31'd0, start}, 1);
      chk("stall_len", {16'd0, len}, 1024);
      chk("stall_rd_en", {31'd0, rd_en}, 0);
    end
    ready = 1'b1;
    drain(1024);
    done_frame(2, 4);

    // underrun while FIFO reports empty
    force_empty = 1'b1;
    write(1024);
    wait_start(2, 1024);
    cyc();
    repeat (6) begin
      chk("ur_pulse", {31'd0, underrun}, 1);
      chk("ur_rd_en", {31'd0, rd_en}, 0);
      chk("ur_valid", {31'd0, tx_valid}, 0);
      cyc();
    end
    force_empty = 1'b0;
    drain(1024);
    done_frame(2, 5);
    chk("ur_idle", {31'd0, underrun}, 0);

    // reset in the middle of a drain
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    write(1024);
    wait_start(2, 1024);
    v0 = vcnt;
    n = 0;
    while (vcnt - v0 < 300 && n < 1000) begin
      cyc();
      n++;
    end
    chk("pre_rst_bytes", vcnt - v0, 300);
    rst = 1'b1;
    data_req = 1'b0;
    cyc();
    chk("mr_rd_en", {31'd0, rd_en}, 0);
    chk("mr_start", {31'd0, start}, 0);
    chk("mr_len", {16'd0, len}, 0);
    chk("mr_valid", {31'd0, tx_valid}, 0);
    chk("mr_underrun", {31'd0, underrun}, 0);
    chk("mr_fcnt", {16'd0, fcnt}, 0);
    chk("mr_level", {19'd0, level}, 724);
    rst = 1'b0;
    data_req = 1'b1;
    wait_start(50, 724);
    drain(724);
    done_frame(2, 1);
    chk("end_level", {19'd0, level}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/udp_tx_fifo_sched.md
# udp_tx_fifo_sched

Read-side controller for the 8-bit, 4096-deep synchronous UDP TX payload FIFO. It watches the FIFO read water level and decides when a UDP frame is ready: either a full packet's worth of bytes, or a partial packet after an idle timeout. It then requests a frame from the UDP TX engine and drains exactly the announced byte count into it. It sits between the payload FIFO's read port and the UDP/IP transmit engine.

## Interface
- DEPTH_WIDTH, 12, FIFO address width; water level is DEPTH_WIDTH+1 bits.
- PKT_LEN, 1024, payload bytes per full frame; legal range 1..2**DEPTH_WIDTH.
- FLUSH_TIMEOUT, 50000, IDLE cycles with nonzero level before a partial frame is sent; must be ≥1.
- clk  in  1  single clock for the block.
- rst  in  1  synchronous, active-high reset.
- fifo_rd_water_level  in  DEPTH_WIDTH+1  FIFO read-side occupancy in bytes.
- fifo_rd_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe.
- fifo_rd_data  in  8  FIFO read data; valid one cycle after fifo_rd_en (no output register).
- udp_tx_start  out  1  frame request; held high until accepted.
- udp_tx_ready  in  1  engine accepts the request in a cycle where udp_tx_start & udp_tx_ready.
- udp_tx_len  out  16  payload length of the requested frame; stable from start until done.
- udp_tx_data_req  in  1  engine pulls one payload byte this cycle.
- udp_tx_data  out  8  payload byte (direct from fifo_rd_data).
- udp_tx_data_valid  out  1  udp_tx_data is valid.
- udp_tx_done  in  1  single-cycle pulse: frame fully transmitted.
- underrun_err  out  1  single-cycle pulse: byte requested while the FIFO was empty.
- frame_cnt  out  16  frames completed; wraps at 0xFFFF→0.

## Operation
- States: IDLE, REQ, SEND, WAIT_DONE. Reset → IDLE.
- IDLE:
  - If level ≥ PKT_LEN: latch len=PKT_LEN and go to REQ.
  - Else if level ≠ 0 and flush_timer == FLUSH_TIMEOUT-1: latch len=level and go to REQ.
  - Full-packet check takes priority over timeout.
- flush_timer counts only in IDLE with level ≠ 0. It clears when level == 0, on leaving IDLE, and on rst.
- REQ: udp_tx_start=1. When udp_tx_ready=1, go to SEND and set remaining=len.
- SEND:
  - fifo_rd_en = udp_tx_data_req & (remaining≠0) & ~fifo_rd_empty.
  - remaining decrements on each fifo_rd_en.
  - udp_tx_data_req & remaining≠0 & fifo_rd_empty → underrun_err pulse, no read, remaining unchanged.
  - When remaining goes 1→0 on a read, go to WAIT_DONE.
  - udp_tx_data_req with remaining==0 is ignored.
- WAIT_DONE: on udp_tx_done, increment frame_cnt and go to IDLE. udp_tx_done in any other state is ignored.
- udp_tx_len is a register, loaded on the IDLE→REQ transition only.
- Width rule: the 13-bit level is zero-extended into the 16-bit len. remaining is 13 bits.
- Reset mid-frame: everything returns to reset values in the next cycle. No partial drain; unread bytes stay in the FIFO.

## Timing
- Reset values: fifo_rd_en=0, udp_tx_start=0, udp_tx_len=0, udp_tx_data_valid=0, underrun_err=0, frame_cnt=0. udp_tx_data follows fifo_rd_data.
- The threshold seen at cycle t gives udp_tx_start=1 at t+1.
- fifo_rd_en is combinational from udp_tx_data_req in SEND. udp_tx_data_valid = fifo_rd_en delayed by one cycle, so latency from data_req to data is 1 cycle.
- Back-to-back requests stream one byte per cycle.
- The last udp_tx_data_valid occurs in the first WAIT_DONE cycle.
- A new frame can request earliest 2 cycles after udp_tx_done: IDLE evaluation, then REQ.

## Structure
- Package udp_tx_sched_pkg holds:
  - the state enum (2 bits: IDLE=0, REQ=1, SEND=2, WAIT_DONE=3);
  - the LEN_W=16 constant.
- One sub-module, udp_tx_flush_timer: a counter with clear/enable inputs and a terminal-count output at FLUSH_TIMEOUT-1.
- The FSM, length latch, remaining counter and frame counter live in the top level.

## Test plan
- Write 1024 bytes 0xFF..down; engine ready immediately, data_req held high → start 1 cycle after level hits 1024, udp_tx_len=1024, 1024 valid bytes in write order, fifo_rd_en low after the last byte, level returns to 0.
- Write 100 bytes with FLUSH_TIMEOUT=50 → start exactly 50 cycles after level becomes nonzero; udp_tx_len=100; exactly 100 bytes delivered.
- Write 2500 bytes, done pulsed 5 cycles after each drain → two 1024-byte frames, then a timeout frame of 452; frame_cnt=3.
- udp_tx_ready held low 20 cycles → udp_tx_start held and udp_tx_len constant throughout; no fifo_rd_en before acceptance.
- Level forced to 1024 while rd_empty=1 in SEND, data_req high → underrun_err pulses each cycle, remaining unchanged; no valid.
- rst for 1 cycle mid-SEND after 300 bytes → all outputs at reset values next cycle; state IDLE; remaining FIFO bytes are re-framed from the current level.
